// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame/oversampling
// constants used by the receiver, transmitter and tick generator.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_SB_TICKS   = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; RST_VAL sets the value both
// stages take in reset so the output starts at the input's idle level.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample the pre-edge values; blocking here would collapse the two flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop recovery with a one-cycle done
// strobe, framing-error flag and break suppression.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int SB_TICKS   = DEF_SB_TICKS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 s_tick,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done_tick,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int S_W = $clog2(max_int(OVERSAMPLE, SB_TICKS));
  localparam int N_W = $clog2(DATA_BITS);

  localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic [1:0]           state;
  logic [S_W-1:0]       s_cnt;
  logic [N_W-1:0]       n_cnt;
  logic [DATA_BITS-1:0] shreg;
  // Low after a frame whose stop sampled low; a held-low line cannot restart
  // a frame until it has been seen high again.
  logic                 armed;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign busy = (state != ST_IDLE);

  // NOTE: the shift register and output registers are reset explicitly, since
  // dout must read 0 out of reset and after a mid-frame reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      shreg        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      armed        <= 1'b1;
    end else begin
      rx_done_tick <= 1'b0;
      if (rx_s) armed <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (!rx_s && armed) begin
            state <= ST_START;
            s_cnt <= '0;
          end
        end

        ST_START: begin
          if (s_tick) begin
            if (s_cnt == S_HALF) begin
              if (!rx_s) begin
                state <= ST_DATA;
                s_cnt <= '0;
                n_cnt <= '0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              s_cnt <= s_cnt + S_W'(1);
            end
          end
        end

        ST_DATA: begin
          if (s_tick) begin
            if (s_cnt == S_BIT) begin
              s_cnt <= '0;
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              if (n_cnt == N_LAST) state <= ST_STOP;
              else                 n_cnt <= n_cnt + N_W'(1);
            end else begin
              s_cnt <= s_cnt + S_W'(1);
            end
          end
        end

        default: begin
          if (s_tick) begin
            if (s_cnt == S_STOP) begin
              dout         <= shreg;
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
              armed        <= rx_s;
              state        <= ST_IDLE;
            end else begin
              s_cnt <= s_cnt + S_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule
